// File: rtl/multicycle_controller_pkg.sv
// mips_ctrl_pkg: shared state, opcode/funct, ALU and mux encodings for the multicycle controller
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    REX, RWB, IEX, IWB, BEQ, JMP, JAL, JR
  } state_t;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_JR     = 6'b000111;
  localparam logic [5:0] OP_PACKED = 6'b011111;
  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_SUB    = 6'b100010;
  localparam logic [5:0] FN_AND    = 6'b100100;
  localparam logic [5:0] FN_OR     = 6'b100101;
  localparam logic [5:0] FN_SLT    = 6'b101010;
  localparam logic [5:0] FN_SLLV   = 6'b000100;
  localparam logic [5:0] FN_SRLV   = 6'b000110;
  localparam logic [5:0] FN_SRAV   = 6'b000111;
  localparam logic [5:0] FN_PACKED = 6'b010000;
  localparam logic [4:0] SH_PADD   = 5'b00000;
  localparam logic [4:0] SH_PSUB   = 5'b00100;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLLV  = 4'b1010;
  localparam logic [3:0] ALU_SRLV  = 4'b1011;
  localparam logic [3:0] ALU_SRAV  = 4'b1100;
  localparam logic [3:0] ALU_PADD  = 4'b1000;
  localparam logic [3:0] ALU_PSUB  = 4'b1001;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMMS = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;
endpackage

// File: rtl/multicycle_controller_if.sv
// mc_if: controller <-> datapath/memory control bundle
interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       link;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_control;
  logic [1:0] pc_src;
  logic       instr_done;
  logic       illegal_instr;
  modport master (
    input  opcode, funct, shamt, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, pc_write, reg_write, reg_dst,
           mem_to_reg, link, alu_src_a, alu_src_b, alu_control, pc_src,
           instr_done, illegal_instr
  );
  modport slave (
    output opcode, funct, shamt, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, pc_write, reg_write, reg_dst,
           mem_to_reg, link, alu_src_a, alu_src_b, alu_control, pc_src,
           instr_done, illegal_instr
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// mc_alu_decoder: funct/shamt to alu_control for R-type and packed ops, with illegal-encoding flag
module mc_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic [4:0] i_shamt,
  output logic [3:0] o_alu_control,
  output logic       o_illegal
);
  logic w_sh0;
  assign w_sh0 = (i_shamt == 5'd0);
  always_comb begin
    o_alu_control = ALU_ADD;
    o_illegal     = 1'b0;
    if (i_opcode == OP_RTYPE) begin
      case (i_funct)
        FN_ADD:  o_alu_control = ALU_ADD;
        FN_SUB:  o_alu_control = ALU_SUB;
        FN_AND:  o_alu_control = ALU_AND;
        FN_OR:   o_alu_control = ALU_OR;
        FN_SLT:  o_alu_control = ALU_SLT;
        FN_SLLV: o_alu_control = ALU_SLLV;
        FN_SRLV: begin o_alu_control = ALU_SRLV; o_illegal = !w_sh0; end
        FN_SRAV: begin o_alu_control = ALU_SRAV; o_illegal = !w_sh0; end
        default: o_illegal = 1'b1;
      endcase
    end else if (i_opcode == OP_PACKED) begin
      o_alu_control = (i_shamt == SH_PSUB) ? ALU_PSUB : ALU_PADD;
      o_illegal     = (i_funct != FN_PACKED) || !(w_sh0 || i_shamt == SH_PSUB);
    end
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: MIPS32 multicycle control FSM sequencing the shared datapath
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  mc_if.master bus
);
  state_t     r_state, w_next;
  logic [3:0] w_alu_control;
  logic       w_alu_illegal;
  mc_alu_decoder u_dec (
    .i_opcode      (bus.opcode),
    .i_funct       (bus.funct),
    .i_shamt       (bus.shamt),
    .o_alu_control (w_alu_control),
    .o_illegal     (w_alu_illegal)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next            = r_state;
    bus.mem_req       = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.link          = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_B;
    bus.alu_control   = 4'b0000;
    bus.pc_src        = PC_ALU;
    bus.instr_done    = 1'b0;
    bus.illegal_instr = 1'b0;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        bus.mem_req     = 1'b1;
        bus.alu_src_b   = SRCB_4;
        bus.alu_control = ALU_ADD;
        bus.ir_write    = bus.mem_ready;
        bus.pc_write    = bus.mem_ready;
        w_next          = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b   = SRCB_IMMS;
        bus.alu_control = ALU_ADD;
        case (bus.opcode)
          OP_RTYPE, OP_PACKED: w_next = w_alu_illegal ? FETCH : REX;
          OP_LW, OP_SW:        w_next = MEMADR;
          OP_BEQ:              w_next = BEQ;
          OP_ADDI:             w_next = IEX;
          OP_J:                w_next = JMP;
          OP_JAL:              w_next = JAL;
          OP_JR:               w_next = JR;
          default:             w_next = FETCH;
        endcase
        // every legal dispatch leaves FETCH, so returning there marks the encoding illegal
        bus.illegal_instr = (w_next == FETCH);
      end
      MEMADR: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_src_b   = SRCB_IMM;
        bus.alu_control = ALU_ADD;
        w_next          = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        w_next      = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = FETCH;
      end
      MEMWR: begin
        bus.mem_req    = 1'b1;
        bus.mem_write  = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = bus.mem_ready;
        w_next         = bus.mem_ready ? FETCH : MEMWR;
      end
      REX: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = w_alu_control;
        w_next          = RWB;
      end
      RWB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = FETCH;
      end
      IEX: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_src_b   = SRCB_IMM;
        bus.alu_control = ALU_ADD;
        w_next          = IWB;
      end
      IWB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = FETCH;
      end
      BEQ: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_control = ALU_SUB;
        bus.pc_src      = PC_ALUOUT;
        bus.pc_write    = bus.zero;
        bus.instr_done  = 1'b1;
        w_next          = FETCH;
      end
      JMP, JAL: begin
        bus.pc_src     = PC_JUMP;
        bus.pc_write   = 1'b1;
        bus.reg_write  = (r_state == JAL);
        bus.link       = (r_state == JAL);
        bus.instr_done = 1'b1;
        w_next         = FETCH;
      end
      JR: begin
        bus.pc_src     = PC_REG;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
        w_next         = FETCH;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed cycle-by-cycle output checks of the multicycle controller
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;
  mc_if bus ();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // fields: mem_req mem_write iord ir_write pc_write reg_write reg_dst mem_to_reg link alu_src_a alu_src_b alu_control pc_src instr_done illegal_instr
  function automatic logic [19:0] e(input logic mr, mw, io, ir, pw, rw, rd, m2r, lk, sa,
                                     input logic [1:0] sb, input logic [3:0] ac,
                                     input logic [1:0] ps, input logic dn, il);
    return {mr, mw, io, ir, pw, rw, rd, m2r, lk, sa, sb, ac, ps, dn, il};
  endfunction
  logic [19:0] obs;
  assign obs = {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.link, bus.alu_src_a,
                bus.alu_src_b, bus.alu_control, bus.pc_src, bus.instr_done, bus.illegal_instr};
  localparam logic [19:0] S_IDLE   = 20'h0;
  logic [19:0] s_fetch, s_fstall, s_dec, s_dec_ill, s_memadr, s_memrd, s_memwb,
               s_memwr, s_wstall, s_rex_sub, s_rex_psub, s_rwb, s_iex, s_iwb,
               s_beq_t, s_beq_n, s_jmp, s_jal, s_jr;
  task automatic cyc(input string tag, input logic [19:0] exp_v);
    #1;
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    @(negedge clk);
  endtask
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh);
    bus.opcode = op;
    bus.funct  = fn;
    bus.shamt  = sh;
  endtask
  initial begin
    s_fetch    = e(1,0,0,1,1,0,0,0,0,0,2'b01,4'b0010,2'b00,0,0);
    s_fstall   = e(1,0,0,0,0,0,0,0,0,0,2'b01,4'b0010,2'b00,0,0);
    s_dec      = e(0,0,0,0,0,0,0,0,0,0,2'b11,4'b0010,2'b00,0,0);
    s_dec_ill  = e(0,0,0,0,0,0,0,0,0,0,2'b11,4'b0010,2'b00,0,1);
    s_memadr   = e(0,0,0,0,0,0,0,0,0,1,2'b10,4'b0010,2'b00,0,0);
    s_memrd    = e(1,0,1,0,0,0,0,0,0,0,2'b00,4'b0000,2'b00,0,0);
    s_memwb    = e(0,0,0,0,0,1,0,1,0,0,2'b00,4'b0000,2'b00,1,0);
    s_memwr    = e(1,1,1,0,0,0,0,0,0,0,2'b00,4'b0000,2'b00,1,0);
    s_wstall   = e(1,1,1,0,0,0,0,0,0,0,2'b00,4'b0000,2'b00,0,0);
    s_rex_sub  = e(0,0,0,0,0,0,0,0,0,1,2'b00,4'b0110,2'b00,0,0);
    s_rex_psub = e(0,0,0,0,0,0,0,0,0,1,2'b00,4'b1001,2'b00,0,0);
    s_rwb      = e(0,0,0,0,0,1,1,0,0,0,2'b00,4'b0000,2'b00,1,0);
    s_iex      = e(0,0,0,0,0,0,0,0,0,1,2'b10,4'b0010,2'b00,0,0);
    s_iwb      = e(0,0,0,0,0,1,0,0,0,0,2'b00,4'b0000,2'b00,1,0);
    s_beq_t    = e(0,0,0,0,1,0,0,0,0,1,2'b00,4'b0110,2'b01,1,0);
    s_beq_n    = e(0,0,0,0,0,0,0,0,0,1,2'b00,4'b0110,2'b01,1,0);
    s_jmp      = e(0,0,0,0,1,0,0,0,0,0,2'b00,4'b0000,2'b10,1,0);
    s_jal      = e(0,0,0,0,1,1,0,0,1,0,2'b00,4'b0000,2'b10,1,0);
    s_jr       = e(0,0,0,0,1,0,0,0,0,0,2'b00,4'b0000,2'b11,1,0);
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    instr(6'b100011, 6'd0, 5'd0);
    @(negedge clk);
    cyc("reset_held", S_IDLE);
    reset = 1'b0;
    cyc("idle", S_IDLE);
    cyc("lw_fetch", s_fetch);
    cyc("lw_decode", s_dec);
    cyc("lw_memadr", s_memadr);
    cyc("lw_memrd", s_memrd);
    cyc("lw_memwb", s_memwb);
    instr(6'b101011, 6'd0, 5'd0);
    bus.mem_ready = 1'b0;
    cyc("sw_fetch_stall", s_fstall);
    bus.mem_ready = 1'b1;
    cyc("sw_fetch", s_fetch);
    cyc("sw_decode", s_dec);
    cyc("sw_memadr", s_memadr);
    bus.mem_ready = 1'b0;
    cyc("sw_memwr_stall1", s_wstall);
    cyc("sw_memwr_stall2", s_wstall);
    bus.mem_ready = 1'b1;
    cyc("sw_memwr_done", s_memwr);
    instr(6'b000000, 6'b100010, 5'd0);
    cyc("sub_fetch", s_fetch);
    cyc("sub_decode", s_dec);
    cyc("sub_rex", s_rex_sub);
    cyc("sub_rwb", s_rwb);
    instr(6'b000000, 6'b000110, 5'd3);
    cyc("srlv3_fetch", s_fetch);
    cyc("srlv3_decode_illegal", s_dec_ill);
    instr(6'b111111, 6'd0, 5'd0);
    cyc("badop_fetch", s_fetch);
    cyc("badop_decode_illegal", s_dec_ill);
    instr(6'b000100, 6'd0, 5'd0);
    bus.zero = 1'b1;
    cyc("beqt_fetch", s_fetch);
    cyc("beqt_decode", s_dec);
    cyc("beqt_beq", s_beq_t);
    bus.zero = 1'b0;
    cyc("beqn_fetch", s_fetch);
    cyc("beqn_decode", s_dec);
    cyc("beqn_beq", s_beq_n);
    instr(6'b011111, 6'b010000, 5'b00100);
    cyc("psub_fetch", s_fetch);
    cyc("psub_decode", s_dec);
    cyc("psub_rex", s_rex_psub);
    cyc("psub_rwb", s_rwb);
    instr(6'b011111, 6'b010000, 5'b00010);
    cyc("pbad_fetch", s_fetch);
    cyc("pbad_decode_illegal", s_dec_ill);
    instr(6'b000011, 6'd0, 5'd0);
    cyc("jal_fetch", s_fetch);
    cyc("jal_decode", s_dec);
    cyc("jal_jal", s_jal);
    instr(6'b000010, 6'd0, 5'd0);
    cyc("j_fetch", s_fetch);
    cyc("j_decode", s_dec);
    cyc("j_jmp", s_jmp);
    instr(6'b000111, 6'd0, 5'd0);
    cyc("jr_fetch", s_fetch);
    cyc("jr_decode", s_dec);
    cyc("jr_jr", s_jr);
    instr(6'b001000, 6'd0, 5'd0);
    cyc("addi_fetch", s_fetch);
    cyc("addi_decode", s_dec);
    cyc("addi_iex", s_iex);
    cyc("addi_iwb", s_iwb);
    instr(6'b100011, 6'd0, 5'd0);
    cyc("lw2_fetch", s_fetch);
    cyc("lw2_decode", s_dec);
    cyc("lw2_memadr", s_memadr);
    bus.mem_ready = 1'b0;
    #1;
    total++;
    assert (obs === s_memrd) passed++;
    else $error("FAIL lw2_memrd_stall: observed %h expected %h", obs, s_memrd);
    #2 reset = 1'b1;
    #1;
    total++;
    assert (obs === S_IDLE) passed++;
    else $error("FAIL async_reset_drop: observed %h expected %h", obs, S_IDLE);
    @(negedge clk);
    cyc("reset_mid_held", S_IDLE);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    cyc("post_reset_idle", S_IDLE);
    cyc("post_reset_fetch", s_fetch);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
